// File: rtl/knn_pio_pkg.sv
// Shared constants for the KNN reset PIO master: FSM state codes and PIO register map.
package knn_pio_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WR_DIR = 3'd1;
  localparam logic [2:0] ST_WR_SET = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_WR_CLR = 3'd4;
  localparam logic [2:0] ST_RD     = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  localparam int PIO_ADDR_DATA = 0;
  localparam int PIO_ADDR_DIR  = 1;
  localparam logic PIO_DIR_OUT = 1'b1;
endpackage

// File: rtl/knn_reset_pio_master_hold_counter.sv
// knn_hold_counter: loadable saturating down-counter with a zero flag, used for the reset hold time.
module knn_hold_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = load_val_i;
    else if (dec_i && cnt_q != 0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/knn_reset_pio_master.sv
// Avalon-MM sequencer pulsing the KNN reset line through a 1-bit PIO slave, then reading it back.
// Define AVM_WAITREQUEST_EN to honour m_waitrequest on write and read cycles.
module knn_reset_pio_master
  import knn_pio_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 2,
  parameter int READ_LATENCY = 1,
  parameter int DEFAULT_LEN  = 16,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  pulse_len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic              m_read,
  output logic [DATA_W-1:0] m_writedata,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_waitrequest
);
  localparam int RD_W = $clog2(READ_LATENCY + 2);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [RD_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic              err_q, err_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_val;
  logic              stall;
  logic              unused_ok;

`ifdef AVM_WAITREQUEST_EN
  assign stall     = m_waitrequest;
  assign unused_ok = ^{m_readdata[DATA_W-1:1], cnt_val};
`else
  assign stall     = 1'b0;
  assign unused_ok = ^{m_readdata[DATA_W-1:1], m_waitrequest, cnt_val};
`endif

  knn_hold_counter #(.CNT_W(CNT_W)) u_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (cnt_load),
    .load_val_i(len_q - 1'b1),
    .dec_i     (cnt_dec),
    .cnt_o     (cnt_val),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    err_d    = err_q;
    rd_cnt_d = rd_cnt_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        len_d   = (pulse_len == '0) ? CNT_W'(DEFAULT_LEN) : pulse_len;
        err_d   = 1'b0;
        state_d = ST_WR_DIR;
      end
      ST_WR_DIR: if (!stall) state_d = ST_WR_SET;
      ST_WR_SET: if (!stall) begin
        cnt_load = 1'b1;
        state_d  = ST_HOLD;
      end
      ST_HOLD: if (cnt_zero) state_d = ST_WR_CLR;
               else          cnt_dec = 1'b1;
      ST_WR_CLR: if (!stall) begin
        rd_cnt_d = '0;
        state_d  = ST_RD;
      end
      // Stall only gates the first read cycle; latency counting starts once it is released.
      ST_RD: if (rd_cnt_q != '0 || !stall) begin
        if (rd_cnt_q == RD_W'(READ_LATENCY)) begin
          if (m_readdata[0]) err_d = 1'b1;
          rd_cnt_d = '0;
          state_d  = ST_DONE;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus strobes are registered from the next state so they line up with state_q.
  logic              wr_d, cs_d, rd_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic              wbit_d;

  always_comb begin
    wr_d   = (state_d == ST_WR_DIR) || (state_d == ST_WR_SET) || (state_d == ST_WR_CLR);
    rd_d   = (state_d == ST_RD);
    cs_d   = wr_d || rd_d;
    addr_d = (state_d == ST_WR_DIR) ? ADDR_W'(PIO_ADDR_DIR) : ADDR_W'(PIO_ADDR_DATA);
    wbit_d = (state_d == ST_WR_DIR) ? PIO_DIR_OUT : (state_d == ST_WR_SET);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      rd_cnt_q     <= '0;
      err_q        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_read       <= 1'b0;
      m_address    <= '0;
      m_writedata  <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_cnt_q     <= rd_cnt_d;
      err_q        <= err_d;
      busy         <= busy_d;
      done         <= done_d;
      m_chipselect <= cs_d;
      m_write_n    <= !wr_d;
      m_read       <= rd_d;
      m_address    <= addr_d;
      m_writedata  <= {{(DATA_W-1){1'b0}}, wbit_d};
    end

  assign error = err_q;
endmodule

// File: tb/tb_knn_reset_pio_master.sv
// Directed bench for knn_reset_pio_master against a behavioural 1-bit PIO slave model.
module tb_knn_reset_pio_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pulse_len = '0;
  logic        busy, done, error;
  logic [1:0]  m_address;
  logic        m_chipselect, m_write_n, m_read;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = '0;
  logic        m_waitrequest;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  knn_reset_pio_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pulse_len(pulse_len),
    .busy(busy), .done(done), .error(error),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_read(m_read), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest)
  );

  // PIO slave model: not reset by the master's reset, so it keeps its last written values.
  logic pio_dir = 1'b0, pio_data = 1'b0, force_hi = 1'b0;
  int   stall_left = 0;
  logic pin;
  assign pin = force_hi ? 1'b1 : (pio_dir & pio_data);

`ifdef AVM_WAITREQUEST_EN
  assign m_waitrequest = (stall_left > 0) && m_chipselect && !m_write_n &&
                         (m_address == 2'd0) && m_writedata[0];
`else
  assign m_waitrequest = 1'b0;
`endif

  always @(posedge clk) begin
    if (m_waitrequest) stall_left <= stall_left - 1;
    if (m_chipselect && !m_write_n && !m_waitrequest) begin
      if (m_address == 2'd0) pio_data <= m_writedata[0];
      if (m_address == 2'd1) pio_dir  <= m_writedata[0];
    end
    m_readdata <= (m_address == 2'd0) ? {31'd0, pin} :
                  (m_address == 2'd1) ? {31'd0, pio_dir} : 32'd0;
  end

  // Monitors: sample away from the active edge.
  logic [2:0] wr_q[$];
  int line_hi = 0, busy_cyc = 0, n_done = 0, n_reads = 0, set_held = 0;
  logic rd_prev = 1'b0;
  always @(negedge clk) begin
    if (m_chipselect && !m_write_n && !m_waitrequest) wr_q.push_back({m_address, m_writedata[0]});
    if (m_chipselect && !m_write_n && m_address == 2'd0 && m_writedata[0]) set_held++;
    if (pio_dir && pio_data) line_hi++;
    if (busy) busy_cyc++;
    if (done) n_done++;
    if (m_read && !rd_prev) n_reads++;
    rd_prev = m_read;
  end

  task automatic pulse_start(input logic [15:0] len);
    @(negedge clk);
    start = 1'b1; pulse_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    n_cmp++; if ({m_chipselect, m_write_n, m_read} !== 3'b010) begin
      n_fail++; $display("FAIL reset_strobes: got cs/wn/rd %b want 010", {m_chipselect, m_write_n, m_read}); end
    n_cmp++; if ({m_address, m_writedata} !== 34'd0) begin
      n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", m_address, m_writedata); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int w0, l0, b0, r0, d0; bit ok;
    w0 = wr_q.size(); l0 = line_hi; b0 = busy_cyc; r0 = n_reads; d0 = n_done;
    pulse_start(16'd4);
    pulse_len = 16'hFFFF;
    wait_done(50, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done want done"); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b want 0", error); end
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_q.size() - w0 != 3) begin n_fail++; $display("FAIL basic_nwrites: got %0d want 3", wr_q.size() - w0); end
    else begin
      n_cmp++; if ({wr_q[w0], wr_q[w0+1], wr_q[w0+2]} !== 9'b011_001_000) begin
        n_fail++; $display("FAIL basic_write_order: got %b %b %b want 011 001 000", wr_q[w0], wr_q[w0+1], wr_q[w0+2]); end
    end
    n_cmp++; if (line_hi - l0 != 5) begin n_fail++; $display("FAIL basic_line_high: got %0d want 5", line_hi - l0); end
    n_cmp++; if (n_reads - r0 != 1) begin n_fail++; $display("FAIL basic_reads: got %0d want 1", n_reads - r0); end
    n_cmp++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", n_done - d0); end
    n_cmp++; if (busy_cyc - b0 != 9) begin n_fail++; $display("FAIL basic_busy_len: got %0d want 9", busy_cyc - b0); end
  endtask

  task automatic test_default_len;
    int l0, b0; bit ok;
    l0 = line_hi; b0 = busy_cyc;
    pulse_start(16'd0);
    wait_done(80, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL default_timeout: got no done want done"); end
    repeat (2) @(negedge clk);
    n_cmp++; if (line_hi - l0 != 17) begin n_fail++; $display("FAIL default_line_high: got %0d want 17", line_hi - l0); end
    n_cmp++; if (busy_cyc - b0 != 21) begin n_fail++; $display("FAIL default_busy_len: got %0d want 21", busy_cyc - b0); end
  endtask

  task automatic test_start_while_busy;
    int w0, d0, l0; bit ok;
    w0 = wr_q.size(); d0 = n_done; l0 = line_hi;
    pulse_start(16'd8);
    repeat (4) @(negedge clk);
    start = 1'b1; pulse_len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(60, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL busy_start_timeout: got no done want done"); end
    repeat (15) @(negedge clk);
    n_cmp++; if (wr_q.size() - w0 != 3) begin n_fail++; $display("FAIL busy_start_writes: got %0d want 3", wr_q.size() - w0); end
    n_cmp++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d want 1", n_done - d0); end
    n_cmp++; if (line_hi - l0 != 9) begin n_fail++; $display("FAIL busy_start_line_high: got %0d want 9", line_hi - l0); end
  endtask

  task automatic test_mismatch;
    bit ok, seen; int l0;
    pulse_start(16'd2);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (m_chipselect && !m_write_n && m_address == 2'd0 && !m_writedata[0]) begin
        force_hi = 1'b1; seen = 1'b1;
      end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL mismatch_no_clr_write: got none want one"); end
    wait_done(40, ok);
    n_cmp++; if (!ok || error !== 1'b1) begin n_fail++; $display("FAIL mismatch_error_at_done: got ok=%b err=%b want 1/1", ok, error); end
    repeat (3) @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL mismatch_sticky: got %b want 1", error); end
    force_hi = 1'b0;
    l0 = line_hi;
    pulse_start(16'd1);
    n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL mismatch_clear_on_start: got %b want 0", error); end
    wait_done(40, ok);
    n_cmp++; if (!ok || error !== 1'b0) begin n_fail++; $display("FAIL mismatch_rerun: got ok=%b err=%b want 1/0", ok, error); end
    @(negedge clk);
    n_cmp++; if (line_hi - l0 != 2) begin n_fail++; $display("FAIL len1_line_high: got %0d want 2", line_hi - l0); end
  endtask

  task automatic test_reset_mid;
    int d0, w0; bit ok;
    pulse_start(16'd10);
    repeat (5) @(negedge clk);
    d0 = n_done;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (m_chipselect !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_immediate: got cs=%b busy=%b want 0/0", m_chipselect, busy); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (n_done != d0) begin n_fail++; $display("FAIL midreset_no_done: got %0d dones want 0", n_done - d0); end
    w0 = wr_q.size();
    pulse_start(16'd3);
    wait_done(40, ok);
    n_cmp++; if (!ok || error !== 1'b0) begin n_fail++; $display("FAIL midreset_rerun: got ok=%b err=%b want 1/0", ok, error); end
    @(negedge clk);
    n_cmp++; if (wr_q.size() - w0 != 3) begin n_fail++; $display("FAIL midreset_writes: got %0d want 3", wr_q.size() - w0); end
  endtask

`ifdef AVM_WAITREQUEST_EN
  task automatic test_waitrequest;
    int s0, l0; bit ok;
    s0 = set_held; l0 = line_hi;
    stall_left = 3;
    pulse_start(16'd4);
    wait_done(60, ok);
    n_cmp++; if (!ok || error !== 1'b0) begin n_fail++; $display("FAIL wait_done: got ok=%b err=%b want 1/0", ok, error); end
    @(negedge clk);
    n_cmp++; if (set_held - s0 != 4) begin n_fail++; $display("FAIL wait_set_held: got %0d want 4", set_held - s0); end
    n_cmp++; if (line_hi - l0 != 5) begin n_fail++; $display("FAIL wait_line_high: got %0d want 5", line_hi - l0); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_default_len;
    test_start_while_busy;
    test_mismatch;
    test_reset_mid;
`ifdef AVM_WAITREQUEST_EN
    test_waitrequest;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
